// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, count width and FSM state encoding for the SRAM responder
package sram_pkg;
  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETTLE,
    RD_VALID,
    WR_ACTIVE,
    WR_ABORT
  } state_e;
endpackage

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - controller-side address/strobe and responder status signals
interface sram_responder_if #(
  parameter int ADDR_W = sram_pkg::ADDR_W_DEF
);
  import sram_pkg::*;

  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_WE_N;
  logic              wr_commit;
  logic              rd_valid;
  logic              err_short_write;
  logic              err_addr_change;
  logic [CNT_W-1:0]  commit_count;

  modport master (
    output SRAM_ADDR, SRAM_WE_N,
    input  wr_commit, rd_valid, err_short_write, err_addr_change, commit_count
  );

  modport slave (
    input  SRAM_ADDR, SRAM_WE_N,
    output wr_commit, rd_valid, err_short_write, err_addr_change, commit_count
  );
endinterface

// File: rtl/sram_array.sv
// rtl/sram_array.sv - DEPTH x DATA_W storage, synchronous write and asynchronous read, no reset
module sram_array #(
  parameter int DEPTH  = 65536,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - behavioural async-SRAM target: timed reads, WE_N-width-checked writes, error flags
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 65536,
  parameter int READ_LAT  = 2,
  parameter int WRITE_MIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  sram_responder_if.slave   bus,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [2:0] RD_LAT3  = 3'(READ_LAT);
  localparam logic [2:0] WR_MIN3  = 3'(WRITE_MIN);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_n_q, we_n_d;
  logic [2:0]          settle_q, settle_d;
  logic [2:0]          low_q, low_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    waddr_q, waddr_d;
  logic                wr_commit_q, wr_commit_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_s_q, err_s_d;
  logic                err_a_q, err_a_d;
  logic                array_we;
  logic [DATA_W-1:0]   rd_data;
  logic                addr_chg;
  logic [2:0]          settle_inc;

  sram_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
    .clk   (clk),
    .we    (array_we),
    .waddr (waddr_q),
    .wdata (wdata_q),
    .raddr (bus.SRAM_ADDR[IDX_W-1:0]),
    .rdata (rd_data)
  );

  // Bus release is decoded straight from the pin so the controller never sees a contention cycle.
  assign SRAM_DQ    = bus.SRAM_WE_N ? dout_q : {DATA_W{1'bz}};
  assign addr_chg   = (bus.SRAM_ADDR != addr_q);
  assign settle_inc = settle_q + 3'd1;

  assign bus.rd_valid        = (state_q == RD_VALID) && !addr_chg && bus.SRAM_WE_N;
  assign bus.wr_commit       = wr_commit_q;
  assign bus.err_short_write = err_s_q;
  assign bus.err_addr_change = err_a_q;
  assign bus.commit_count    = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_n_q      <= 1'b1;
      settle_q    <= '0;
      low_q       <= '0;
      dout_q      <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      wr_commit_q <= 1'b0;
      count_q     <= '0;
      err_s_q     <= 1'b0;
      err_a_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_n_q      <= we_n_d;
      settle_q    <= settle_d;
      low_q       <= low_d;
      dout_q      <= dout_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      wr_commit_q <= wr_commit_d;
      count_q     <= count_d;
      err_s_q     <= err_s_d;
      err_a_q     <= err_a_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = bus.SRAM_ADDR;
    we_n_d      = bus.SRAM_WE_N;
    settle_d    = settle_q;
    low_d       = low_q;
    dout_d      = dout_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    wr_commit_d = 1'b0;
    count_d     = count_q;
    err_s_d     = err_s_q;
    err_a_d     = err_a_q;
    array_we    = 1'b0;

    if (!bus.SRAM_WE_N) begin
      if (we_n_q) begin
        state_d = WR_ACTIVE;
        low_d   = 3'd1;
        wdata_d = SRAM_DQ;
        waddr_d = bus.SRAM_ADDR[IDX_W-1:0];
      end else if (state_q == WR_ACTIVE) begin
        if (addr_chg) begin
          state_d = WR_ABORT;
          err_a_d = 1'b1;
        end else begin
          wdata_d = SRAM_DQ;
          if (low_q != 3'd7) low_d = low_q + 3'd1;
        end
      end else begin
        // Strobe already low without a seen falling edge (e.g. just out of reset): never commit it.
        state_d = WR_ABORT;
      end
    end else begin
      case (state_q)
        WR_ACTIVE: begin
          settle_d = 3'd1;
          if (low_q >= WR_MIN3) begin
            array_we    = 1'b1;
            wr_commit_d = 1'b1;
            dout_d      = wdata_q;
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            state_d = addr_chg ? RD_SETTLE : RD_VALID;
          end else begin
            err_s_d = 1'b1;
            state_d = RD_SETTLE;
          end
        end
        WR_ABORT: begin
          state_d  = RD_SETTLE;
          settle_d = 3'd1;
        end
        RD_SETTLE: begin
          if (addr_chg) begin
            settle_d = 3'd1;
          end else begin
            settle_d = settle_inc;
            if (settle_inc >= RD_LAT3) begin
              dout_d  = rd_data;
              state_d = RD_VALID;
            end
          end
        end
        default: begin
          if (addr_chg) begin
            state_d  = RD_SETTLE;
            settle_d = 3'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed bench with a transaction-level SRAM model and per-cycle compare
module tb_sram_responder;
  localparam int DEPTH     = 65536;
  localparam int READ_LAT  = 2;
  localparam int WRITE_MIN = 4;
  localparam int NEVER     = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] tb_dq;
  logic        tb_drv;
  wire  [63:0] SRAM_DQ;

  assign SRAM_DQ = tb_drv ? tb_dq : 64'bz;

  sram_responder_if #(.ADDR_W(17)) bus ();

  sram_responder #(
    .ADDR_W(17), .DATA_W(64), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .WRITE_MIN(WRITE_MIN)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .SRAM_DQ(SRAM_DQ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [63:0] mem_m [int];
  int          cyc = 0;
  int          commit_at, valid_from, low_run, count_m;
  logic [16:0] last_addr_m, burst_addr;
  logic [63:0] burst_data;
  logic        burst_bad, last_we_n_m, err_s_m, err_a_m;

  // per-cycle expectations
  logic        chk_en = 1'b0;
  logic        exp_valid, exp_commit, exp_es, exp_ea, exp_dq_chk;
  logic [15:0] exp_count;
  logic [63:0] exp_dq;

  int   rise_cyc = -1;
  int   commit_seen = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
      chk("wr_commit", 64'(bus.wr_commit), 64'(exp_commit));
      chk("err_short_write", 64'(bus.err_short_write), 64'(exp_es));
      chk("err_addr_change", 64'(bus.err_addr_change), 64'(exp_ea));
      chk("commit_count", 64'(bus.commit_count), 64'(exp_count));
      if (exp_dq_chk) begin
        chk("sram_dq", SRAM_DQ, exp_dq);
        chk("sram_dq_known", 64'($isunknown(SRAM_DQ)), 64'd0);
      end
      if (bus.rd_valid && !prev_valid) rise_cyc = cyc;
      if (bus.wr_commit) commit_seen++;
      prev_valid = bus.rd_valid;
    end
  end

  task automatic model_reset();
    last_addr_m = '0;
    last_we_n_m = 1'b1;
    err_s_m     = 1'b0;
    err_a_m     = 1'b0;
    count_m     = 0;
    commit_at   = -1;
    valid_from  = NEVER;
    low_run     = 0;
    burst_bad   = 1'b0;
    burst_addr  = '0;
    burst_data  = '0;
  endtask

  // One bus cycle: drive pins, publish expectations, clock, then advance the model.
  task automatic step(input logic [16:0] a, input logic wn, input logic [63:0] d);
    int   idx;
    logic legal;
    idx = int'(a) % DEPTH;
    bus.SRAM_ADDR = a;
    bus.SRAM_WE_N = wn;
    tb_drv = !wn;
    tb_dq  = d;
    if (reset) begin
      exp_valid = 1'b0; exp_commit = 1'b0; exp_es = 1'b0; exp_ea = 1'b0; exp_count = '0;
    end else begin
      exp_valid  = wn && last_we_n_m && (a == last_addr_m) && (cyc >= valid_from);
      exp_commit = (cyc == commit_at);
      exp_es     = err_s_m;
      exp_ea     = err_a_m;
      exp_count  = 16'(count_m);
    end
    exp_dq_chk = 1'b0;
    exp_dq     = '0;
    if (!wn) begin
      exp_dq_chk = 1'b1;
      exp_dq     = d;
    end else if (reset) begin
      exp_dq_chk = 1'b1;
    end else if (exp_valid && mem_m.exists(idx)) begin
      exp_dq_chk = 1'b1;
      exp_dq     = mem_m[idx];
    end
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if (!wn) begin
        if (last_we_n_m) begin
          low_run = 1; burst_addr = a; burst_data = d; burst_bad = 1'b0;
        end else if (!burst_bad) begin
          if (a != last_addr_m) begin
            burst_bad = 1'b1; err_a_m = 1'b1;
          end else begin
            burst_data = d; low_run++;
          end
        end
      end else if (!last_we_n_m) begin
        legal = !burst_bad && (low_run >= WRITE_MIN);
        if (legal) begin
          mem_m[int'(burst_addr) % DEPTH] = burst_data;
          commit_at = cyc + 1;
          if (count_m < 65535) count_m++;
        end else if (!burst_bad) begin
          err_s_m = 1'b1;
        end
        valid_from = (legal && a == last_addr_m) ? cyc + 1 : cyc + READ_LAT;
      end else if (a != last_addr_m) begin
        valid_from = cyc + READ_LAT;
      end
      last_addr_m = a;
      last_we_n_m = wn;
    end
    cyc++;
  endtask

  // n strobe-low cycles (last data wins), optional address bump from move_at, rise at rise_a, idle reads.
  task automatic wr(input logic [16:0] a, input logic [63:0] d, input int n, input int move_at,
                    input logic [16:0] rise_a, input int idle);
    for (int i = 1; i <= n; i++) begin
      step((move_at != 0 && i >= move_at) ? a + 17'd1 : a, 1'b0,
           (i == n) ? d : (d ^ 64'hFFFF_0000_FFFF_0000 ^ 64'(i)));
    end
    step(rise_a, 1'b1, '0);
    repeat (idle) step(rise_a, 1'b1, '0);
  endtask

  initial begin
    int apply_cyc;
    reset = 1'b1;
    bus.SRAM_ADDR = '0;
    bus.SRAM_WE_N = 1'b1;
    tb_drv = 1'b0;
    tb_dq  = '0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) step(17'h0, 1'b1, '0);
    reset = 1'b0;
    repeat (2) step(17'h0, 1'b1, '0);

    wr(17'h00100, 64'hDEAD_BEEF_0123_4567, 6, 0, 17'h00100, 3);
    chk("first_write_count", 64'(bus.commit_count), 64'd1);
    chk("first_write_pulses", 64'(commit_seen), 64'd1);

    repeat (3) step(17'h00000, 1'b1, '0);
    rise_cyc  = -1;
    apply_cyc = cyc;
    repeat (4) step(17'h00100, 1'b1, '0);
    chk("read_latency", 64'(rise_cyc - apply_cyc), 64'd2);
    chk("read_data_pin", SRAM_DQ, 64'hDEAD_BEEF_0123_4567);

    wr(17'h00200, 64'h2222_2222_2222_2222, 4, 0, 17'h00200, 1);
    wr(17'h00300, 64'h3333_3333_3333_3333, 9, 0, 17'h00300, 1);
    wr(17'h00301, 64'h3434_3434_3434_3434, 5, 0, 17'h00301, 1);
    wr(17'h00500, 64'h5555_5555_5555_5555, 5, 0, 17'h00500, 1);

    wr(17'h00200, 64'h0BAD_0BAD_0BAD_0BAD, 2, 0, 17'h00200, 4);
    chk("short_err_pin", 64'(bus.err_short_write), 64'd1);
    chk("short_count_pin", 64'(bus.commit_count), 64'd5);

    wr(17'h00300, 64'h0BAD_2222_0BAD_2222, 6, 3, 17'h00301, 4);
    repeat (4) step(17'h00300, 1'b1, '0);
    chk("addr_err_pin", 64'(bus.err_addr_change), 64'd1);
    chk("abort_count_pin", 64'(bus.commit_count), 64'd5);

    wr(17'h10100, 64'hA11A_5A11_A5A1_1A5A, 5, 0, 17'h10100, 2);
    repeat (4) step(17'h00100, 1'b1, '0);
    chk("alias_read_pin", SRAM_DQ, 64'hA11A_5A11_A5A1_1A5A);

    wr(17'h00600, 64'h6666_0000_6666_0000, 5, 0, 17'h00601, 3);
    repeat (4) step(17'h00600, 1'b1, '0);

    for (int i = 1; i <= 3; i++) step(17'h00500, 1'b0, 64'hBAD3_0000_0000_0000 + 64'(i));
    reset = 1'b1;
    step(17'h00500, 1'b0, 64'hBAD3_0000_0000_0004);
    step(17'h00500, 1'b1, '0);
    reset = 1'b0;
    repeat (4) step(17'h00500, 1'b1, '0);
    chk("post_reset_count", 64'(bus.commit_count), 64'd0);
    chk("post_reset_errs", 64'({bus.err_short_write, bus.err_addr_change}), 64'd0);
    chk("discarded_write_pin", SRAM_DQ, 64'h5555_5555_5555_5555);

    wr(17'h00400, 64'h4444_4444_4444_4444, 5, 0, 17'h00400, 3);
    chk("after_reset_count", 64'(bus.commit_count), 64'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 17, SRAM word-address width.
REQ-002 Parameter DATA_W, default 64, data-bus width.
REQ-003 Parameter DEPTH, default 65536, power of two; stored words, indexed by SRAM_ADDR[log2(DEPTH)-1:0].
REQ-004 Parameter READ_LAT, default 2, range 1-7; stable-address cycles before read data is valid.
REQ-005 Parameter WRITE_MIN, default 4, range 1-7; minimum WE_N-low cycles for a legal write.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 SRAM_ADDR  input  ADDR_W  word address from the controller.
REQ-009 SRAM_WE_N  input  1  write enable, active-low.
REQ-010 SRAM_DQ  inout  DATA_W  bidirectional data bus.
REQ-011 wr_commit  output  1  one-cycle pulse when a write is committed to the array.
REQ-012 rd_valid  output  1  high while the driven read data matches the current address.
REQ-013 err_short_write  output  1  sticky; a WE_N-low burst was shorter than WRITE_MIN.
REQ-014 err_addr_change  output  1  sticky; SRAM_ADDR changed while WE_N was low.
REQ-015 commit_count  output  16  saturating count of committed writes.

Function
REQ-016 States: IDLE, RD_SETTLE, RD_VALID, WR_ACTIVE, WR_ABORT.
REQ-017 SRAM_DQ is driven with dout_q whenever SRAM_WE_N=1; it is high-Z whenever SRAM_WE_N=0.
- The high-Z condition is decoded combinationally from the pin, so there is no contention cycle.
REQ-018 addr_q registers SRAM_ADDR every cycle; "address change" means SRAM_ADDR != addr_q.
REQ-019 IDLE/RD_VALID, WE_N=1, address change -> RD_SETTLE.
- Settle counter loads 1; rd_valid drops combinationally on the same cycle.
REQ-020 RD_SETTLE, WE_N=1, address stable -> counter increments.
- At counter=READ_LAT: dout_q <= array[addr]; state -> RD_VALID.
- An address change in RD_SETTLE reloads the counter to 1.
REQ-021 rd_valid=1 only in RD_VALID with no address change in the current cycle.
REQ-022 Any state, WE_N=0 with WE_N previously 1 -> WR_ACTIVE.
- Low counter loads 1; wdata_q <= SRAM_DQ; waddr_q <= SRAM_ADDR.
REQ-023 WR_ACTIVE, WE_N=0, address stable -> wdata_q <= SRAM_DQ each cycle (last sample wins); low counter saturates at 7.
REQ-024 WR_ACTIVE, WE_N=0, address change -> WR_ABORT; err_addr_change <= 1.
REQ-025 WR_ABORT holds until WE_N=1, then -> RD_SETTLE; no commit occurs.
REQ-026 WR_ACTIVE, WE_N rises, low counter >= WRITE_MIN:
- array[waddr_q] <= wdata_q; wr_commit pulses on the following cycle; commit_count increments, saturating at 16'hFFFF.
- dout_q <= wdata_q; state -> RD_VALID (write-through read).
REQ-027 WR_ACTIVE, WE_N rises, low counter < WRITE_MIN -> no commit; err_short_write <= 1; state -> RD_SETTLE.
REQ-028 An address change on the same edge WE_N rises counts as a legal commit to waddr_q; the new address then starts RD_SETTLE.
REQ-029 Address bits at and above log2(DEPTH) are ignored; addresses alias modulo DEPTH.
REQ-030 Sticky errors clear only on reset.

Reset
REQ-031 On reset assertion: state=IDLE; dout_q, addr_q, wdata_q, waddr_q, counters, commit_count, wr_commit, err_* = 0.
REQ-032 rd_valid=0 during reset.
REQ-033 SRAM_DQ is driven per REQ-017 with dout_q=0 during reset.
REQ-034 Array contents are not reset.
REQ-035 Reset mid-write discards the pending write.

Structure
REQ-036 Shared package sram_pkg holds: ADDR_W/DATA_W defaults, the state enum, and the 16-bit count width constant.
REQ-037 Storage lives in sub-module sram_array: synchronous write, asynchronous read, DEPTH x DATA_W.

Verification
REQ-038 Write 0xDEAD_BEEF_0123_4567 to 0x00100 (WE_N low 6 cycles, then high) -> wr_commit pulses once; commit_count=1; array[0x100] holds the data.
REQ-039 Then read 0x00100, WE_N=1 -> rd_valid rises exactly READ_LAT=2 cycles after the address is applied; SRAM_DQ=0xDEAD_BEEF_0123_4567.
REQ-040 WE_N low 2 cycles at 0x00200 -> err_short_write=1; no wr_commit; array[0x200] unchanged.
REQ-041 WE_N low, address moves 0x00300->0x00301 on cycle 3 -> err_addr_change=1; neither location written.
REQ-042 Check SRAM_DQ is high-Z in every WE_N=0 cycle, including the first, with no X on the bus.
REQ-043 Assert reset during cycle 4 of a write -> all outputs 0, no commit; a subsequent legal write to 0x00400 commits with commit_count=1.
